// File: rtl/vpu_host_queue.sv
// Host-to-VPU request/response queue with an outstanding-request limit and a sticky error for unexpected responses.
// Optional feature: define VPU_HOST_QUEUE_BYPASS_EN for zero-latency issue when the request FIFO is empty.
module vpu_host_queue #(
  parameter int unsigned SRC_CNT         = 3,
  parameter int unsigned OPERAND_WIDTH   = 24,
  parameter int unsigned STREAM_ID_WIDTH = 4,
  parameter int unsigned REQ_DEPTH       = 4,
  parameter int unsigned RESP_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [7:0]                         opcode_i,
  input  logic [OPERAND_WIDTH-1:0]           dst0_i,
  input  logic [SRC_CNT*OPERAND_WIDTH-1:0]   src_i,
  input  logic [OPERAND_WIDTH-1:0]           imm_i,
  input  logic [STREAM_ID_WIDTH-1:0]         stream_id_i,
  output logic                               dev_valid_o,
  input  logic                               dev_ready_i,
  output logic [7:0]                         dev_opcode_o,
  output logic [OPERAND_WIDTH-1:0]           dev_dst0_o,
  output logic [SRC_CNT*OPERAND_WIDTH-1:0]   dev_src_o,
  output logic [OPERAND_WIDTH-1:0]           dev_imm_o,
  output logic [STREAM_ID_WIDTH-1:0]         dev_stream_id_o,
  input  logic                               dev_resp_valid_i,
  input  logic [STREAM_ID_WIDTH-1:0]         dev_resp_stream_id_i,
  output logic                               dev_resp_ready_o,
  output logic                               resp_valid_o,
  output logic [STREAM_ID_WIDTH-1:0]         resp_stream_id_o,
  input  logic                               resp_ready_i,
  output logic [7:0]                         outstanding_o,
  output logic                               resp_err_o
);

  localparam int unsigned ENT_W = 8 + 2*OPERAND_WIDTH + SRC_CNT*OPERAND_WIDTH + STREAM_ID_WIDTH;
  localparam int unsigned RQ_AW = $clog2(REQ_DEPTH);
  localparam int unsigned RS_AW = $clog2(RESP_DEPTH);
  localparam logic [RQ_AW:0] REQ_FULL  = (RQ_AW+1)'(REQ_DEPTH);
  localparam logic [RS_AW:0] RESP_FULL = (RS_AW+1)'(RESP_DEPTH);
  localparam logic [7:0]     MAX_OUT   = 8'(MAX_OUTSTANDING);

  logic [ENT_W-1:0]           req_mem [REQ_DEPTH];
  logic [RQ_AW-1:0]           req_wr, req_rd;
  logic [RQ_AW:0]             req_cnt;
  logic [STREAM_ID_WIDTH-1:0] resp_mem [RESP_DEPTH];
  logic [RS_AW-1:0]           resp_wr, resp_rd;
  logic [RS_AW:0]             resp_cnt;
  logic [7:0]                 outstanding;
  logic                       err;

  logic [ENT_W-1:0] host_ent, dev_ent;
  logic req_empty, credit, bypass, issue, push, pop, rsp_accept, rsp_pop;

  assign host_ent  = {opcode_i, dst0_i, src_i, imm_i, stream_id_i};
  assign req_empty = (req_cnt == '0);
  assign credit    = (outstanding < MAX_OUT);

`ifdef VPU_HOST_QUEUE_BYPASS_EN
  assign bypass = valid_i & req_empty & credit & dev_ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign ready_o     = (req_cnt < REQ_FULL);
  assign dev_valid_o = (!req_empty && credit) || bypass;
  assign dev_ent     = bypass ? host_ent : req_mem[req_rd];
  assign {dev_opcode_o, dev_dst0_o, dev_src_o, dev_imm_o, dev_stream_id_o} = dev_ent;

  // A bypassed request is issued directly and never occupies a FIFO slot.
  assign issue = dev_valid_o & dev_ready_i;
  assign pop   = issue & !bypass;
  assign push  = valid_i & ready_o & !bypass;

  assign dev_resp_ready_o = (resp_cnt < RESP_FULL);
  assign resp_valid_o     = (resp_cnt != '0);
  assign resp_stream_id_o = resp_mem[resp_rd];
  assign rsp_accept       = dev_resp_valid_i & dev_resp_ready_o;
  assign rsp_pop          = resp_valid_o & resp_ready_i;

  assign outstanding_o = outstanding;
  assign resp_err_o    = err;

  always_ff @(posedge clk) begin
    if (push)       req_mem[req_wr]   <= host_ent;
    if (rsp_accept) resp_mem[resp_wr] <= dev_resp_stream_id_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wr      <= '0;
      req_rd      <= '0;
      req_cnt     <= '0;
      resp_wr     <= '0;
      resp_rd     <= '0;
      resp_cnt    <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (push) req_wr <= req_wr + 1'b1;
      if (pop)  req_rd <= req_rd + 1'b1;
      if (push && !pop)      req_cnt <= req_cnt + 1'b1;
      else if (!push && pop) req_cnt <= req_cnt - 1'b1;

      if (rsp_accept) resp_wr <= resp_wr + 1'b1;
      if (rsp_pop)    resp_rd <= resp_rd + 1'b1;
      if (rsp_accept && !rsp_pop)      resp_cnt <= resp_cnt + 1'b1;
      else if (!rsp_accept && rsp_pop) resp_cnt <= resp_cnt - 1'b1;

      // A response with nothing outstanding is flagged but never decrements below zero.
      if (issue && !(rsp_accept && outstanding != '0))
        outstanding <= outstanding + 8'd1;
      else if (!issue && rsp_accept && outstanding != '0)
        outstanding <= outstanding - 8'd1;

      if (rsp_accept && outstanding == '0) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vpu_host_queue.sv
// Randomized and directed bench for vpu_host_queue, checked against a queue-based reference model.
module tb_vpu_host_queue;
  localparam int SRC_CNT = 3;
  localparam int OW      = 24;
  localparam int SID     = 4;
  localparam int RQD     = 4;
  localparam int RSD     = 4;
  localparam int MAXO    = 2;
  localparam int SRC_W   = SRC_CNT*OW;
  localparam int ENT_W   = 8 + 2*OW + SRC_W + SID;

  logic clk, rst_n;
  logic valid_i, ready_o;
  logic [7:0] opcode_i;
  logic [OW-1:0] dst0_i, imm_i;
  logic [SRC_W-1:0] src_i;
  logic [SID-1:0] stream_id_i;
  logic dev_valid_o, dev_ready_i;
  logic [7:0] dev_opcode_o;
  logic [OW-1:0] dev_dst0_o, dev_imm_o;
  logic [SRC_W-1:0] dev_src_o;
  logic [SID-1:0] dev_stream_id_o;
  logic dev_resp_valid_i, dev_resp_ready_o;
  logic [SID-1:0] dev_resp_stream_id_i;
  logic resp_valid_o, resp_ready_i, resp_err_o;
  logic [SID-1:0] resp_stream_id_o;
  logic [7:0] outstanding_o;

  vpu_host_queue #(
    .SRC_CNT(SRC_CNT), .OPERAND_WIDTH(OW), .STREAM_ID_WIDTH(SID),
    .REQ_DEPTH(RQD), .RESP_DEPTH(RSD), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .ready_o(ready_o), .opcode_i(opcode_i), .dst0_i(dst0_i),
    .src_i(src_i), .imm_i(imm_i), .stream_id_i(stream_id_i),
    .dev_valid_o(dev_valid_o), .dev_ready_i(dev_ready_i), .dev_opcode_o(dev_opcode_o),
    .dev_dst0_o(dev_dst0_o), .dev_src_o(dev_src_o), .dev_imm_o(dev_imm_o),
    .dev_stream_id_o(dev_stream_id_o),
    .dev_resp_valid_i(dev_resp_valid_i), .dev_resp_stream_id_i(dev_resp_stream_id_i),
    .dev_resp_ready_o(dev_resp_ready_o),
    .resp_valid_o(resp_valid_o), .resp_stream_id_o(resp_stream_id_o), .resp_ready_i(resp_ready_i),
    .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [ENT_W-1:0] mq[$];
  logic [SID-1:0]   sq[$];
  int               mout;
  bit               merr;
  logic [SID-1:0]   issued[$];
  logic [SID-1:0]   drained[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_i = 0; opcode_i = '0; dst0_i = '0; src_i = '0; imm_i = '0; stream_id_i = '0;
    dev_ready_i = 0; dev_resp_valid_i = 0; dev_resp_stream_id_i = '0; resp_ready_i = 0;
  endtask

  task automatic rand_fields();
    opcode_i = 8'($urandom);
    dst0_i   = OW'($urandom);
    src_i    = SRC_W'({$urandom, $urandom, $urandom});
    imm_i    = OW'($urandom);
  endtask

  // Called at posedge+1 with inputs already driven; checks mid-cycle, advances the model, returns at next posedge+1.
  task automatic step();
    bit byp, e_dv, e_issue, e_push, e_racc, e_rpop;
    logic [ENT_W-1:0] hent, e_ent;
    #4;
    hent = {opcode_i, dst0_i, src_i, imm_i, stream_id_i};
    byp = 1'b0;
`ifdef VPU_HOST_QUEUE_BYPASS_EN
    byp = valid_i && mq.size() == 0 && mout < MAXO && dev_ready_i;
`endif
    e_dv = (mq.size() != 0 && mout < MAXO) || byp;
    chk("ready", ready_o, mq.size() < RQD);
    chk("dev_valid", dev_valid_o, e_dv);
    if (e_dv) begin
      e_ent = byp ? hent : mq[0];
      chk("dev_fields", {dev_opcode_o, dev_dst0_o, dev_src_o, dev_imm_o, dev_stream_id_o}, e_ent);
    end
    chk("dev_resp_ready", dev_resp_ready_o, sq.size() < RSD);
    chk("resp_valid", resp_valid_o, sq.size() != 0);
    if (sq.size() != 0) chk("resp_id", resp_stream_id_o, sq[0]);
    chk("outstanding", outstanding_o, mout);
    chk("resp_err", resp_err_o, merr);

    if (dev_valid_o && dev_ready_i) issued.push_back(dev_stream_id_o);
    if (resp_valid_o && resp_ready_i) drained.push_back(resp_stream_id_o);

    e_issue = e_dv && dev_ready_i;
    e_push  = valid_i && mq.size() < RQD && !byp;
    e_racc  = dev_resp_valid_i && sq.size() < RSD;
    e_rpop  = sq.size() != 0 && resp_ready_i;
    if (e_issue && !byp) void'(mq.pop_front());
    if (e_push) mq.push_back(hent);
    if (e_rpop) void'(sq.pop_front());
    if (e_racc) sq.push_back(dev_resp_stream_id_i);
    if (e_racc && mout == 0) merr = 1'b1;
    mout = mout + int'(e_issue) - int'(e_racc && mout > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      if (mq.size() == 0 && mout == 0 && sq.size() == 0) break;
      valid_i = 0; dev_ready_i = 1; resp_ready_i = 1;
      dev_resp_valid_i = (mout > 0);
      dev_resp_stream_id_i = SID'($urandom);
      step();
    end
    idle_inputs();
    chk("drain_done", (mq.size() == 0 && mout == 0 && sq.size() == 0), 1);
  endtask

  initial begin
    logic exp_same, exp_next;
    idle_inputs();
    mout = 0; merr = 0;
    rst_n = 0;
    #1;
    chk("rst_dev_valid", dev_valid_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", resp_err_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_dev_resp_ready", dev_resp_ready_o, 1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Request FIFO fills with the VPU stalled, then issues in order.
    issued.delete();
    valid_i = 1; dev_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      rand_fields(); stream_id_i = SID'(i);
      step();
    end
    chk("full_ready_low", ready_o, 0);
    rand_fields(); stream_id_i = 4'd4;
    step();
    chk("full_fifth_held", ready_o, 0);
    valid_i = 0; dev_ready_i = 1; resp_ready_i = 1;
    for (int c = 0; c < 12; c++) begin
      dev_resp_valid_i = (mout > 0);
      dev_resp_stream_id_i = SID'($urandom);
      step();
    end
    dev_resp_valid_i = 0;
    for (int k = 0; k < 4; k++) chk($sformatf("issue_order_%0d", k), issued[k], k);
    chk("issue_count", issued.size(), 4);
    drain();

    // Outstanding limit, then simultaneous issue and response.
    issued.delete();
    dev_ready_i = 1; resp_ready_i = 1; valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      rand_fields(); stream_id_i = SID'(8 + i);
      step();
    end
    valid_i = 0;
    step(); step();
    chk("limit_dev_valid", dev_valid_o, 0);
    chk("limit_outstanding", outstanding_o, 2);
    chk("limit_issued", issued.size(), 2);
    dev_resp_valid_i = 1; dev_resp_stream_id_i = 4'd8;
    step();
    dev_resp_stream_id_i = 4'd9;
    step();
    chk("same_cycle_outstanding", outstanding_o, 1);
    chk("third_issued_count", issued.size(), 3);
    chk("third_issued_id", issued[2], 10);
    dev_resp_stream_id_i = 4'd10;
    step();
    dev_resp_valid_i = 0;
    drain();

    // Response with nothing outstanding.
    resp_ready_i = 1; dev_resp_valid_i = 1; dev_resp_stream_id_i = 4'd5;
    step();
    dev_resp_valid_i = 0;
    chk("unexp_resp_valid", resp_valid_o, 1);
    chk("unexp_resp_id", resp_stream_id_o, 5);
    chk("unexp_err", resp_err_o, 1);
    chk("unexp_outstanding", outstanding_o, 0);
    step();

    // Response FIFO fills under host backpressure, then drains in order.
    drained.delete();
    resp_ready_i = 0;
    for (int i = 1; i <= 4; i++) begin
      dev_resp_valid_i = 1; dev_resp_stream_id_i = SID'(i);
      step();
    end
    chk("resp_full_ready_low", dev_resp_ready_o, 0);
    dev_resp_stream_id_i = 4'd5;
    step();
    dev_resp_valid_i = 0; resp_ready_i = 1;
    for (int c = 0; c < 4; c++) step();
    for (int k = 0; k < 4; k++) chk($sformatf("resp_order_%0d", k), drained[k], k + 1);
    chk("resp_drained_count", drained.size(), 4);
    idle_inputs();

    // Issue latency from an idle queue.
`ifdef VPU_HOST_QUEUE_BYPASS_EN
    exp_same = 1'b1; exp_next = 1'b0;
`else
    exp_same = 1'b0; exp_next = 1'b1;
`endif
    dev_ready_i = 1; resp_ready_i = 1;
    rand_fields(); opcode_i = 8'h12; stream_id_i = 4'd3; valid_i = 1;
    #2;
    chk("lat_same_valid", dev_valid_o, exp_same);
    if (dev_valid_o) chk("lat_same_opcode", dev_opcode_o, 8'h12);
    step();
    valid_i = 0;
    #1;
    chk("lat_next_valid", dev_valid_o, exp_next);
    if (dev_valid_o) chk("lat_next_opcode", dev_opcode_o, 8'h12);
    step();
    drain();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rand_fields();
      valid_i     = ($urandom % 3) != 0;
      stream_id_i = SID'($urandom);
      dev_ready_i = ($urandom % 4) != 0;
      resp_ready_i = ($urandom % 3) != 0;
      dev_resp_valid_i = (mout > 0) && ($urandom % 2);
      dev_resp_stream_id_i = SID'($urandom);
      step();
    end

    // Asynchronous reset mid-operation discards everything.
    #2 rst_n = 0;
    #1;
    mq.delete(); sq.delete(); mout = 0; merr = 0;
    idle_inputs();
    chk("midrst_dev_valid", dev_valid_o, 0);
    chk("midrst_resp_valid", resp_valid_o, 0);
    chk("midrst_outstanding", outstanding_o, 0);
    chk("midrst_err", resp_err_o, 0);
    @(posedge clk); @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    dev_ready_i = 1; resp_ready_i = 1;
    step();
    for (int c = 0; c < 200; c++) begin
      rand_fields();
      valid_i     = ($urandom % 2);
      stream_id_i = SID'($urandom);
      dev_ready_i = ($urandom % 2);
      resp_ready_i = ($urandom % 2);
      dev_resp_valid_i = (mout > 0) && ($urandom % 2);
      dev_resp_stream_id_i = SID'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/vpu_host_queue.md
VPU_HOST_QUEUE -- requirements
Module: vpu_host_queue

Interface
REQ-001 Parameter SRC_CNT, default 3, number of source operand fields per instruction (1..4).
REQ-002 Parameter OPERAND_WIDTH, default 24, width of dst0, each src and imm field.
REQ-003 Parameter STREAM_ID_WIDTH, default 4, stream ID width.
REQ-004 Parameter REQ_DEPTH, default 4, request FIFO entries; power of two, >=2.
REQ-005 Parameter RESP_DEPTH, default 4, response FIFO entries; power of two, >=2.
REQ-006 Parameter MAX_OUTSTANDING, default 8, maximum issued-but-unanswered requests (1..255).
REQ-007 Clock and reset are fixed: one clock, clk; reset rst_n, asynchronous, active-low.
REQ-008 Ports, as name, direction, width, meaning:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- valid_i  in  1  host request valid
- ready_o  out  1  host request ready
- opcode_i  in  8  opcode
- dst0_i  in  OPERAND_WIDTH  destination
- src_i  in  SRC_CNT*OPERAND_WIDTH  sources; field k at [k*OPERAND_WIDTH +: OPERAND_WIDTH]
- imm_i  in  OPERAND_WIDTH  immediate
- stream_id_i  in  STREAM_ID_WIDTH  request stream ID
- dev_valid_o  out  1  request valid to VPU
- dev_ready_i  in  1  VPU ready
- dev_opcode_o, dev_dst0_o, dev_src_o, dev_imm_o, dev_stream_id_o  out  same widths as host fields  issued request
- dev_resp_valid_i  in  1  VPU response valid
- dev_resp_stream_id_i  in  STREAM_ID_WIDTH  VPU response stream ID
- dev_resp_ready_o  out  1  response accepted from VPU
- resp_valid_o  out  1  response valid to host
- resp_stream_id_o  out  STREAM_ID_WIDTH  response stream ID to host
- resp_ready_i  in  1  host response ready
- outstanding_o  out  8  current outstanding count
- resp_err_o  out  1  sticky: VPU response while outstanding count was 0

Function
REQ-009 Host accept = valid_i & ready_o; ready_o = 1 when request FIFO count < REQ_DEPTH; no pop-through when full (ready_o = 0 even if a pop occurs that cycle).
REQ-010 Accepted request (opcode, dst0, all src fields, imm, stream_id) is written to the request FIFO unmodified, in order.
REQ-011 dev_valid_o = request FIFO not empty & outstanding_o < MAX_OUTSTANDING; dev_* fields = FIFO head, held stable while dev_valid_o & !dev_ready_i.
REQ-012 Issue = dev_valid_o & dev_ready_i pops the head; minimum host-accept-to-dev_valid_o latency is 1 cycle.
REQ-013 Simultaneous push and pop leaves the FIFO count unchanged; read/write pointers wrap modulo REQ_DEPTH.
REQ-014 outstanding_o increments on issue and decrements on response accept (dev_resp_valid_i & dev_resp_ready_o); both in one cycle leaves it unchanged.
REQ-015 A response accepted while outstanding_o = 0 is still forwarded, outstanding_o stays 0 (no underflow), and resp_err_o is set until reset.
REQ-016 dev_resp_ready_o = response FIFO count < RESP_DEPTH; accepted stream IDs are queued in order.
REQ-017 resp_valid_o = response FIFO not empty; resp_stream_id_o = head; pop on resp_valid_o & resp_ready_i; response latency 1 cycle.
REQ-018 Backpressure on resp_ready_i never blocks request issue except through the MAX_OUTSTANDING limit.

Reset
REQ-019 On rst_n low, asynchronously: both FIFOs empty, pointers 0, outstanding_o = 0, resp_err_o = 0, dev_valid_o = 0, resp_valid_o = 0, ready_o = 1 after release, dev_resp_ready_o = 1 after release.
REQ-020 Reset mid-operation discards all queued requests and responses; no issue or response occurs in the cycle after release.

Configuration
REQ-021 Macro VPU_HOST_QUEUE_BYPASS_EN: when defined, if request FIFO empty, outstanding_o < MAX_OUTSTANDING and dev_ready_i = 1, a valid host request drives dev_* combinationally, is issued the same cycle and is not written to the FIFO (latency 0); when undefined, every request passes through the FIFO (latency 1).

Verification
REQ-022 Push 4 requests with dev_ready_i = 0, REQ_DEPTH 4 -> ready_o = 0 after 4th; 5th held; release dev_ready_i -> 4 issued in order, stream IDs 0,1,2,3.
REQ-023 MAX_OUTSTANDING 2, dev_ready_i = 1, no responses, 3 requests -> exactly 2 issued, dev_valid_o = 0, outstanding_o = 2; one response -> 3rd issued.
REQ-024 Issue and response in same cycle with outstanding_o = 1 -> outstanding_o stays 1.
REQ-025 Response stream ID 5 with outstanding_o = 0 -> resp_stream_id_o = 5 next cycle, resp_err_o = 1, outstanding_o = 0.
REQ-026 resp_ready_i = 0, 5 responses, RESP_DEPTH 4 -> dev_resp_ready_o = 0 after 4th; host drains IDs in order.
REQ-027 Bypass defined, idle, dev_ready_i = 1, request opcode 0x12 -> dev_valid_o and dev_opcode_o = 0x12 same cycle; undefined -> next cycle.
